// File: rtl/axi3_hp_bram_slave.sv
// AXI3 HP-port responder backed by on-chip memory. It lets the stream DMA
// write path and read path loop back in fabric without the PS DDR.
// The write and read engines are fully independent; each one handles a
// single outstanding burst and streams one beat per clock.
module axi3_hp_bram_slave #(
  parameter int          ADDR_W = 10,
  parameter logic [31:0] BASE   = 32'h1000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  // write address channel
  input  logic [5:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [3:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic        awvalid,
  output logic        awready,
  // write data channel
  input  logic [5:0]  wid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  // write response channel
  output logic [5:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready,
  // read address channel
  input  logic [5:0]  arid,
  input  logic [31:0] araddr,
  input  logic [3:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic        arvalid,
  output logic        arready,
  // read data channel
  output logic [5:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  // completed-burst counters
  output logic [15:0] wr_bursts,
  output logic [15:0] rd_bursts
);

  localparam int         DEPTH       = 1 << ADDR_W;
  localparam int         WIN_W       = 32 - ADDR_W - 2;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_FIXED = 2'b00;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

  logic [31:0] mem [DEPTH];

  w_state_t          w_state_q, w_state_d;
  logic [5:0]        w_id_q, w_id_d;
  logic [ADDR_W-1:0] w_addr_q, w_addr_d;
  logic [3:0]        w_len_q, w_len_d;
  logic [3:0]        w_cnt_q, w_cnt_d;
  logic              w_fixed_q, w_fixed_d;
  logic              w_err_q, w_err_d;
  logic [15:0]       wr_bursts_q, wr_bursts_d;
  logic              mem_we;
  logic              w_last_beat;
  logic              w_beat_err;

  r_state_t          r_state_q, r_state_d;
  logic [5:0]        rid_q, rid_d;
  logic [ADDR_W-1:0] r_addr_q, r_addr_d;
  logic [3:0]        r_len_q, r_len_d;
  logic [3:0]        r_cnt_q, r_cnt_d;
  logic              r_fixed_q, r_fixed_d;
  logic              r_err_q, r_err_d;
  logic              rvalid_q, rvalid_d;
  logic              rlast_q, rlast_d;
  logic [1:0]        rresp_q, rresp_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [15:0]       rd_bursts_q, rd_bursts_d;

  // wid and the byte offset are not needed: AXI2S never interleaves and
  // every access is a full 32-bit word.
  logic unused_ok;
  assign unused_ok = ^{wid, awaddr[1:0], araddr[1:0]};

  // A request is rejected for its whole burst if it starts outside the
  // window, is not a 32-bit transfer, or asks for WRAP/reserved bursts.
  function automatic logic req_err(input logic [WIN_W-1:0] win,
                                   input logic [2:0] size,
                                   input logic [1:0] burst);
    return (win != BASE[31:ADDR_W+2]) || (size != 3'b010) || burst[1];
  endfunction

  assign w_last_beat = (w_cnt_q == w_len_q);
  assign w_beat_err  = (wlast != w_last_beat);

  // Write engine: accept AW, commit strobed beats, then hold the response.
  // Beats accepted before a wlast violation shows up are already written;
  // from the offending beat onwards nothing more reaches memory.
  always_comb begin
    w_state_d   = w_state_q;
    w_id_d      = w_id_q;
    w_addr_d    = w_addr_q;
    w_len_d     = w_len_q;
    w_cnt_d     = w_cnt_q;
    w_fixed_d   = w_fixed_q;
    w_err_d     = w_err_q;
    wr_bursts_d = wr_bursts_q;
    mem_we      = 1'b0;
    awready     = 1'b0;
    wready      = 1'b0;
    bvalid      = 1'b0;
    bresp       = RESP_OKAY;
    case (w_state_q)
      W_IDLE: begin
        awready = 1'b1;
        if (awvalid) begin
          w_state_d = W_DATA;
          w_id_d    = awid;
          w_addr_d  = awaddr[ADDR_W+1:2];
          w_len_d   = awlen;
          w_cnt_d   = 4'd0;
          w_fixed_d = (awburst == BURST_FIXED);
          w_err_d   = req_err(awaddr[31:ADDR_W+2], awsize, awburst);
        end
      end
      W_DATA: begin
        wready = 1'b1;
        if (wvalid) begin
          mem_we   = !(w_err_q || w_beat_err);
          w_err_d  = w_err_q || w_beat_err;
          w_addr_d = w_addr_q + {{(ADDR_W-1){1'b0}}, !w_fixed_q};
          w_cnt_d  = w_cnt_q + 4'd1;
          if (w_last_beat) begin
            w_state_d = W_RESP;
          end
        end
      end
      W_RESP: begin
        bvalid = 1'b1;
        bresp  = w_err_q ? RESP_SLVERR : RESP_OKAY;
        if (bready) begin
          w_state_d   = W_IDLE;
          wr_bursts_d = wr_bursts_q + 16'd1;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Byte-lane memory write; the array itself is never reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) begin
          mem[w_addr_q][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  // Read engine: fetch the first beat on AR, then the next beat on every
  // R handshake. Memory is sampled before this edge's write lands, so a
  // same-cycle write to the same word returns the old contents.
  always_comb begin
    r_state_d   = r_state_q;
    rid_d       = rid_q;
    r_addr_d    = r_addr_q;
    r_len_d     = r_len_q;
    r_cnt_d     = r_cnt_q;
    r_fixed_d   = r_fixed_q;
    r_err_d     = r_err_q;
    rvalid_d    = rvalid_q;
    rlast_d     = rlast_q;
    rresp_d     = rresp_q;
    rdata_d     = rdata_q;
    rd_bursts_d = rd_bursts_q;
    arready     = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        arready = 1'b1;
        if (arvalid) begin
          r_state_d = R_DATA;
          rid_d     = arid;
          r_len_d   = arlen;
          r_cnt_d   = 4'd0;
          r_fixed_d = (arburst == BURST_FIXED);
          r_err_d   = req_err(araddr[31:ADDR_W+2], arsize, arburst);
          r_addr_d  = araddr[ADDR_W+1:2] +
                      {{(ADDR_W-1){1'b0}}, (arburst != BURST_FIXED)};
          rvalid_d  = 1'b1;
          rlast_d   = (arlen == 4'd0);
          rresp_d   = r_err_d ? RESP_SLVERR : RESP_OKAY;
          rdata_d   = r_err_d ? 32'd0 : mem[araddr[ADDR_W+1:2]];
        end
      end
      R_DATA: begin
        if (rready) begin
          if (rlast_q) begin
            r_state_d   = R_IDLE;
            rvalid_d    = 1'b0;
            rlast_d     = 1'b0;
            rd_bursts_d = rd_bursts_q + 16'd1;
          end else begin
            r_cnt_d  = r_cnt_q + 4'd1;
            rlast_d  = ((r_cnt_q + 4'd1) == r_len_q);
            rdata_d  = r_err_q ? 32'd0 : mem[r_addr_q];
            r_addr_d = r_addr_q + {{(ADDR_W-1){1'b0}}, !r_fixed_q};
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // All control and output registers; reset aborts any burst immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state_q   <= W_IDLE;
      w_id_q      <= '0;
      w_addr_q    <= '0;
      w_len_q     <= '0;
      w_cnt_q     <= '0;
      w_fixed_q   <= 1'b0;
      w_err_q     <= 1'b0;
      wr_bursts_q <= '0;
      r_state_q   <= R_IDLE;
      rid_q       <= '0;
      r_addr_q    <= '0;
      r_len_q     <= '0;
      r_cnt_q     <= '0;
      r_fixed_q   <= 1'b0;
      r_err_q     <= 1'b0;
      rvalid_q    <= 1'b0;
      rlast_q     <= 1'b0;
      rresp_q     <= '0;
      rdata_q     <= '0;
      rd_bursts_q <= '0;
    end else begin
      w_state_q   <= w_state_d;
      w_id_q      <= w_id_d;
      w_addr_q    <= w_addr_d;
      w_len_q     <= w_len_d;
      w_cnt_q     <= w_cnt_d;
      w_fixed_q   <= w_fixed_d;
      w_err_q     <= w_err_d;
      wr_bursts_q <= wr_bursts_d;
      r_state_q   <= r_state_d;
      rid_q       <= rid_d;
      r_addr_q    <= r_addr_d;
      r_len_q     <= r_len_d;
      r_cnt_q     <= r_cnt_d;
      r_fixed_q   <= r_fixed_d;
      r_err_q     <= r_err_d;
      rvalid_q    <= rvalid_d;
      rlast_q     <= rlast_d;
      rresp_q     <= rresp_d;
      rdata_q     <= rdata_d;
      rd_bursts_q <= rd_bursts_d;
    end
  end

  assign bid       = w_id_q;
  assign rid       = rid_q;
  assign rvalid    = rvalid_q;
  assign rlast     = rlast_q;
  assign rresp     = rresp_q;
  assign rdata     = rdata_q;
  assign wr_bursts = wr_bursts_q;
  assign rd_bursts = rd_bursts_q;

endmodule

// File: tb/tb_axi3_hp_bram_slave.sv
// Self-checking bench for axi3_hp_bram_slave. A word-array model of the
// memory plus the address/response rules predicts every B and R beat.
module tb_axi3_hp_bram_slave;

  localparam int          ADDR_W = 10;
  localparam int          DEPTH  = 1024;
  localparam logic [31:0] BASE   = 32'h1000_0000;
  localparam int          TMO    = 200;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  awid, wid, bid, arid, rid;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  awlen, wstrb, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic [15:0] wr_bursts, rd_bursts;

  axi3_hp_bram_slave #(.ADDR_W(ADDR_W), .BASE(BASE)) dut (
    .clk(clk), .rst_n(rst_n),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready),
    .wr_bursts(wr_bursts), .rd_bursts(rd_bursts)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_mem [DEPTH];
  int          model_wr = 0;
  int          model_rd = 0;
  logic [31:0] wb_data [16];
  logic [3:0]  wb_strb [16];
  logic [31:0] last_rdata;

  typedef struct {
    logic [31:0] addr;
    int          len;
    logic [2:0]  size;
    logic [1:0]  burst;
    int          early;
    logic [1:0]  exp_resp;
  } wvec_t;

  wvec_t vecs [10];

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic timeoutFail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: no handshake within %0d cycles", name, TMO);
  endtask

  function automatic logic sigSel(input int sel);
    case (sel)
      0:       return awready;
      1:       return wready;
      2:       return bvalid;
      3:       return arready;
      default: return rvalid;
    endcase
  endfunction

  // Wait (sampling on falling edges) for a ready/valid to be high.
  task automatic waitHigh(input int sel, input string name, output bit ok);
    int n = 0;
    ok = 1'b0;
    forever begin
      @(negedge clk);
      if (sigSel(sel)) begin
        ok = 1'b1;
        break;
      end
      n++;
      if (n >= TMO) begin
        timeoutFail(name);
        break;
      end
    end
  endtask

  function automatic bit modelErr(input logic [31:0] addr, input logic [2:0] size,
                                  input logic [1:0] burst);
    return ((addr >> (ADDR_W + 2)) != (BASE >> (ADDR_W + 2))) || (size != 3'd2) ||
           (burst == 2'b10) || (burst == 2'b11);
  endfunction

  function automatic int beatWord(input logic [31:0] addr, input logic [1:0] burst,
                                  input int i);
    int start = int'((addr >> 2) & 32'(DEPTH - 1));
    if (burst == 2'b00) return start;
    return (start + i) % DEPTH;
  endfunction

  task automatic modelStore(input int w, input logic [31:0] d, input logic [3:0] s);
    for (int b = 0; b < 4; b++) begin
      if (s[b]) model_mem[w][8*b +: 8] = d[8*b +: 8];
    end
  endtask

  // Full write transaction using wb_data/wb_strb; early<0 means wlast on
  // the true last beat, otherwise wlast is raised only on beat 'early'.
  task automatic writeBurst(input logic [5:0] id, input logic [31:0] addr, input int len,
                            input logic [2:0] size, input logic [1:0] burst,
                            input int early, input bit gaps, output logic [1:0] resp);
    bit ok;
    bit bad;
    bit lastv;
    resp = 2'bxx;
    awid = id; awaddr = addr; awlen = 4'(len); awsize = size; awburst = burst;
    awvalid = 1'b1;
    waitHigh(0, "aw_handshake", ok);
    @(posedge clk); #1;
    awvalid = 1'b0;
    if (!ok) return;
    bad = modelErr(addr, size, burst);
    for (int i = 0; i <= len; i++) begin
      if (gaps) begin
        while ($urandom_range(0, 2) == 0) begin
          wvalid = 1'b0;
          @(posedge clk); #1;
        end
      end
      lastv = (early >= 0) ? (i == early) : (i == len);
      wid = id; wdata = wb_data[i]; wstrb = wb_strb[i]; wlast = lastv; wvalid = 1'b1;
      waitHigh(1, "w_handshake", ok);
      @(posedge clk); #1;
      wvalid = 1'b0; wlast = 1'b0;
      if (!ok) return;
      if (lastv != (i == len)) bad = 1'b1;
      if (!bad) modelStore(beatWord(addr, burst, i), wb_data[i], wb_strb[i]);
    end
    checkOutput("bvalid_after_last_w", bvalid, 1);
    if (gaps) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    bready = 1'b1;
    waitHigh(2, "b_handshake", ok);
    if (ok) begin
      resp = bresp;
      checkOutput("bid", bid, id);
      checkOutput("bresp", bresp, bad ? 2'b10 : 2'b00);
      model_wr++;
    end
    @(posedge clk); #1;
    bready = 1'b0;
    checkOutput("bvalid_drop", bvalid, 0);
  endtask

  // Full read transaction; mode 0 rready=1, mode 1 toggles 1010.., mode 2 random.
  task automatic readBurst(input logic [5:0] id, input logic [31:0] addr, input int len,
                           input logic [2:0] size, input logic [1:0] burst, input int mode);
    bit ok;
    bit bad;
    bit hs;
    int cyc = 0;
    logic [31:0] expv;
    arid = id; araddr = addr; arlen = 4'(len); arsize = size; arburst = burst;
    arvalid = 1'b1;
    waitHigh(3, "ar_handshake", ok);
    @(posedge clk); #1;
    arvalid = 1'b0;
    if (!ok) return;
    checkOutput("rvalid_1clk_after_ar", rvalid, 1);
    bad = modelErr(addr, size, burst);
    for (int i = 0; i <= len; i++) begin
      expv = bad ? 32'd0 : model_mem[beatWord(addr, burst, i)];
      forever begin
        case (mode)
          0:       rready = 1'b1;
          1:       rready = (cyc % 2 == 0);
          default: rready = 1'($urandom_range(0, 1));
        endcase
        @(negedge clk);
        cyc++;
        if (!rvalid) begin
          timeoutFail("rvalid_during_burst");
          rready = 1'b0;
          return;
        end
        checkOutput("rdata", rdata, expv);
        checkOutput("rlast", rlast, (i == len));
        checkOutput("rresp", rresp, bad ? 2'b10 : 2'b00);
        checkOutput("rid", rid, id);
        hs = rready;
        if (hs) last_rdata = rdata;
        @(posedge clk); #1;
        if (hs) break;
        if (cyc > TMO) begin
          timeoutFail("r_stall");
          rready = 1'b0;
          return;
        end
      end
    end
    rready = 1'b0;
    checkOutput("rvalid_drop", rvalid, 0);
    model_rd++;
    if (mode == 0) checkOutput("full_rate_cycles", cyc, len + 1);
  endtask

  // One table vector: write it, check the listed response, then read the
  // same word span back in-window to confirm what memory now holds.
  task automatic applyStimulus(input wvec_t v, input int idx);
    logic [1:0]  resp;
    logic [1:0]  rb;
    logic [31:0] raddr;
    for (int i = 0; i < 16; i++) begin
      wb_data[i] = $urandom;
      wb_strb[i] = 4'hF;
    end
    writeBurst(6'(idx), v.addr, v.len, v.size, v.burst, v.early, 1'b0, resp);
    checkOutput($sformatf("vec%0d_bresp", idx), resp, v.exp_resp);
    rb    = (v.burst == 2'b00) ? 2'b00 : 2'b01;
    raddr = (BASE & 32'hFFFF_F000) | (v.addr & 32'h0000_0FFF);
    readBurst(6'(idx + 32), raddr, v.len, 3'd2, rb, idx % 3);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [1:0]  resp;
    logic [31:0] oldv;
    logic [31:0] newv;
    bit          ok;

    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
    rready = 1'b0;

    vecs[0] = '{BASE + 32'h14,  0, 3'd2, 2'b01, -1, 2'b00};
    vecs[1] = '{BASE - 32'h4,   0, 3'd2, 2'b01, -1, 2'b10};
    vecs[2] = '{BASE + 32'h20,  1, 3'd2, 2'b10, -1, 2'b10};
    vecs[3] = '{BASE + 32'h24,  0, 3'd1, 2'b01, -1, 2'b10};
    vecs[4] = '{BASE + 32'h30,  3, 3'd2, 2'b01,  2, 2'b10};
    vecs[5] = '{BASE + 32'h40,  3, 3'd2, 2'b11, -1, 2'b10};
    vecs[6] = '{32'h1000_1000,  0, 3'd2, 2'b01, -1, 2'b10};
    vecs[7] = '{BASE + 32'hFFC, 3, 3'd2, 2'b01, -1, 2'b00};
    vecs[8] = '{BASE + 32'h50,  3, 3'd2, 2'b00, -1, 2'b00};
    vecs[9] = '{BASE + 32'h60,  2, 3'd2, 2'b01, 16, 2'b10};

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("rst_awready", awready, 1);
    checkOutput("rst_arready", arready, 1);
    checkOutput("rst_wready", wready, 0);
    checkOutput("rst_bvalid", bvalid, 0);
    checkOutput("rst_rvalid", rvalid, 0);
    checkOutput("rst_rlast", rlast, 0);
    checkOutput("rst_ids", {bid, rid}, 0);
    checkOutput("rst_resps", {bresp, rresp}, 0);
    checkOutput("rst_rdata", rdata, 0);
    checkOutput("rst_counters", {wr_bursts, rd_bursts}, 0);

    // Single beat write and read-back
    wb_data[0] = 32'hDEADBEEF; wb_strb[0] = 4'hF;
    writeBurst(6'h2A, BASE + 32'h10, 0, 3'd2, 2'b01, -1, 1'b0, resp);
    checkOutput("t1_bresp", resp, 2'b00);
    readBurst(6'h15, BASE + 32'h10, 0, 3'd2, 2'b01, 0);
    checkOutput("t1_rdata", last_rdata, 32'hDEADBEEF);
    checkOutput("t1_wr_bursts", wr_bursts, 1);
    checkOutput("t1_rd_bursts", rd_bursts, 1);

    // Fill the whole memory so every later read has a known expectation
    for (int blk = 0; blk < DEPTH / 16; blk++) begin
      for (int i = 0; i < 16; i++) begin
        wb_data[i] = $urandom;
        wb_strb[i] = 4'hF;
      end
      writeBurst(6'(blk), BASE + 32'(blk * 64), 15, 3'd2, 2'b01, -1, 1'b0, resp);
    end

    // 16-beat INCR with data=i, read back stalled and at full rate
    for (int i = 0; i < 16; i++) begin
      wb_data[i] = 32'(i);
      wb_strb[i] = 4'hF;
    end
    writeBurst(6'h01, BASE, 15, 3'd2, 2'b01, -1, 1'b1, resp);
    readBurst(6'h02, BASE, 15, 3'd2, 2'b01, 1);
    checkOutput("t2_last_beat", last_rdata, 32'd15);
    readBurst(6'h03, BASE, 15, 3'd2, 2'b01, 0);

    // Partial strobe merge
    wb_data[0] = 32'hFFFF_FFFF; wb_strb[0] = 4'hF;
    writeBurst(6'h04, BASE + 32'h70, 0, 3'd2, 2'b01, -1, 1'b0, resp);
    wb_data[0] = 32'h1234_5678; wb_strb[0] = 4'b0101;
    writeBurst(6'h05, BASE + 32'h70, 0, 3'd2, 2'b01, -1, 1'b0, resp);
    readBurst(6'h06, BASE + 32'h70, 0, 3'd2, 2'b01, 0);
    checkOutput("t3_strobe_merge", last_rdata, 32'hFF34_FF78);

    // Table of error / address-rule write vectors
    for (int v = 0; v < 10; v++) applyStimulus(vecs[v], v);

    // Out-of-window read: four zero beats with SLVERR
    readBurst(6'h07, 32'h2000_0000, 3, 3'd2, 2'b01, 2);
    checkOutput("t4_err_rdata", last_rdata, 32'd0);

    // Same-cycle write and read of one word returns the old contents
    oldv = model_mem[32];
    newv = ~oldv;
    awid = 6'h08; awaddr = BASE + 32'h80; awlen = 4'd0; awsize = 3'd2; awburst = 2'b01;
    awvalid = 1'b1;
    waitHigh(0, "conc_aw", ok);
    @(posedge clk); #1;
    awvalid = 1'b0;
    wdata = newv; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1;
    arid = 6'h09; araddr = BASE + 32'h80; arlen = 4'd0; arsize = 3'd2; arburst = 2'b01;
    arvalid = 1'b1;
    @(negedge clk);
    checkOutput("conc_wready", wready, 1);
    checkOutput("conc_arready", arready, 1);
    @(posedge clk); #1;
    wvalid = 1'b0; wlast = 1'b0; arvalid = 1'b0;
    checkOutput("conc_rvalid", rvalid, 1);
    checkOutput("conc_bvalid", bvalid, 1);
    checkOutput("conc_old_data", rdata, oldv);
    rready = 1'b1; bready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0; bready = 1'b0;
    model_mem[32] = newv;
    model_wr++;
    model_rd++;
    readBurst(6'h0A, BASE + 32'h80, 0, 3'd2, 2'b01, 0);
    checkOutput("conc_new_data", last_rdata, newv);

    // Reset asserted while beat 5 of a 16-beat write is being offered
    for (int i = 0; i < 16; i++) begin
      wb_data[i] = $urandom;
      wb_strb[i] = 4'hF;
    end
    awid = 6'h0B; awaddr = BASE + 32'h100; awlen = 4'd15; awsize = 3'd2; awburst = 2'b01;
    awvalid = 1'b1;
    waitHigh(0, "rst_aw", ok);
    @(posedge clk); #1;
    awvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wdata = wb_data[i]; wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b1;
      waitHigh(1, "rst_w", ok);
      @(posedge clk); #1;
      if (ok) model_mem[64 + i] = wb_data[i];
    end
    wdata = wb_data[5];
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_wready", wready, 0);
    checkOutput("midrst_bvalid", bvalid, 0);
    checkOutput("midrst_rvalid", rvalid, 0);
    wvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("postrst_awready", awready, 1);
    checkOutput("postrst_arready", arready, 1);
    checkOutput("postrst_counters", {wr_bursts, rd_bursts}, 0);
    model_wr = 0;
    model_rd = 0;
    readBurst(6'h0C, BASE + 32'h100, 15, 3'd2, 2'b01, 2);

    // Randomized traffic against the model
    for (int t = 0; t < 40; t++) begin
      logic [31:0] addr;
      int          len;
      logic [2:0]  size;
      logic [1:0]  burst;
      int          r;
      addr  = BASE + 32'($urandom_range(0, DEPTH - 1) << 2);
      if ($urandom_range(0, 7) == 0) addr = addr ^ 32'h0010_0000;
      len   = $urandom_range(0, 15);
      size  = ($urandom_range(0, 7) == 0) ? 3'd1 : 3'd2;
      r     = $urandom_range(0, 9);
      burst = (r < 6) ? 2'b01 : (r < 9) ? 2'b00 : 2'b10;
      if ($urandom_range(0, 1) == 0) begin
        for (int i = 0; i < 16; i++) begin
          wb_data[i] = $urandom;
          wb_strb[i] = 4'($urandom_range(0, 15));
        end
        writeBurst(6'($urandom), addr, len, size, burst,
                   ($urandom_range(0, 9) == 0) ? $urandom_range(0, 15) : -1, 1'b1, resp);
      end else begin
        readBurst(6'($urandom), addr, len, size, burst, $urandom_range(0, 2));
      end
    end

    checkOutput("final_wr_bursts", wr_bursts, 16'(model_wr));
    checkOutput("final_rd_bursts", rd_bursts, 16'(model_rd));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
